// File: rtl/mist_io_spi_master.sv
// SPI master for the user_io configuration link: one command byte plus 0-4 payload bytes,
// mode 0, MSB first, with MISO bits collected into a right-aligned 32-bit window.
module mist_io_spi_master #(
  parameter int unsigned ClkDiv = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [7:0]  cmd_i,
  input  logic [31:0] payload_i,
  input  logic [2:0]  len_i,
  output logic [31:0] rx_data_o,
  output logic        rx_valid_o,
  output logic        busy_o,
  output logic        spi_sck_o,
  output logic        spi_ss_n_o,
  output logic        spi_mosi_o,
  input  logic        spi_miso_i
);

  localparam int unsigned CntW = $clog2(ClkDiv + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(ClkDiv - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StHigh, StLow, StGap} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [5:0]      bit_cnt_q;
  logic [5:0]      nbits_q;
  logic [39:0]     sr_q;
  logic [31:0]     rx_q;
  logic            ready_q;
  logic            rx_valid_q;
  logic            sck_q;
  logic            ss_n_q;
  logic            mosi_q;

  logic [2:0] len_clamped;
  logic [5:0] nbits_req;

  always_comb begin
    len_clamped = (len_i > 3'd4) ? 3'd4 : len_i;
    nbits_req   = {len_clamped, 3'b000} + 6'd8;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      nbits_q    <= '0;
      sr_q       <= '0;
      rx_q       <= '0;
      ready_q    <= 1'b1;
      rx_valid_q <= 1'b0;
      sck_q      <= 1'b0;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid_i) begin
            state_q   <= StSetup;
            ready_q   <= 1'b0;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            nbits_q   <= nbits_req;
            sr_q      <= {cmd_i, payload_i};
            rx_q      <= '0;
            ss_n_q    <= 1'b0;
            mosi_q    <= cmd_i[7];
          end
        end
        StSetup, StHigh, StLow, StGap: begin
          if (cnt_q != CntLast) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            cnt_q <= '0;
            if (state_q == StHigh) begin
              state_q <= StLow;
              sck_q   <= 1'b0;
              // The final low phase holds the last bit on MOSI.
              if (bit_cnt_q != nbits_q) begin
                sr_q   <= {sr_q[38:0], 1'b0};
                mosi_q <= sr_q[38];
              end
            end else if (state_q == StGap) begin
              state_q    <= StIdle;
              ready_q    <= 1'b1;
              rx_valid_q <= 1'b1;
            end else if (state_q == StLow && bit_cnt_q == nbits_q) begin
              state_q <= StGap;
              ss_n_q  <= 1'b1;
              mosi_q  <= 1'b0;
            end else begin
              state_q   <= StHigh;
              sck_q     <= 1'b1;
              bit_cnt_q <= bit_cnt_q + 6'd1;
              rx_q      <= {rx_q[30:0], spi_miso_i};
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready_o = ready_q;
  assign busy_o      = ~ready_q;
  assign rx_data_o   = rx_q;
  assign rx_valid_o  = rx_valid_q;
  assign spi_sck_o   = sck_q;
  assign spi_ss_n_o  = ss_n_q;
  assign spi_mosi_o  = mosi_q;

endmodule

// File: tb/tb_mist_io_spi_master.sv
// Bench for mist_io_spi_master: a cycle-offset model of each frame checked every cycle,
// plus directed frames with hand-computed literal expectations.
module tb_mist_io_spi_master;

  localparam int D = 2;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd;
  logic [31:0] payload;
  logic [2:0]  len;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        busy;
  logic        sck;
  logic        ss_n;
  logic        mosi;
  logic        miso;
  logic [1:0]  mode;  // 0: miso=0, 1: miso=1, 2: miso looped from mosi

  int n_checks = 0;
  int n_errors = 0;

  assign miso = (mode == 2'd2) ? mosi : mode[0];

  mist_io_spi_master #(.ClkDiv(D)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_i      (cmd),
    .payload_i  (payload),
    .len_i      (len),
    .rx_data_o  (rx_data),
    .rx_valid_o (rx_valid),
    .busy_o     (busy),
    .spi_sck_o  (sck),
    .spi_ss_n_o (ss_n),
    .spi_mosi_o (mosi),
    .spi_miso_i (miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [39:0] got, input logic [39:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Frame model: position within a frame is a cycle offset k from the accept edge.
  logic       m_active = 1'b0;
  int         m_k = 0;
  int         m_n = 8;
  logic       m_bits [40];
  logic [1:0] m_mode = 2'd0;
  logic [31:0] m_rx = '0;

  function automatic logic samp(input int i);
    return (m_mode == 2'd2) ? m_bits[i] : m_mode[0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_k = 0;
      m_rx = '0;
    end else begin
      logic rdy;
      int nl;
      rdy = !m_active || (m_k == D * (2 + 2 * m_n));
      if (m_active) begin
        m_k++;
        if (m_k > D * (2 + 2 * m_n)) m_active = 1'b0;
        else if (m_k < D * (1 + 2 * m_n) && m_k % D == 0 && (m_k / D) % 2 == 1)
          m_rx = {m_rx[30:0], samp((m_k / D - 1) / 2)};
      end
      if (rdy && cmd_valid) begin
        nl = (len > 3'd4) ? 4 : int'(len);
        m_n = 8 * (1 + nl);
        for (int i = 0; i < 40; i++)
          m_bits[i] = (i < 8) ? cmd[7 - i] : payload[31 - (i - 8)];
        m_mode = mode;
        m_active = 1'b1;
        m_k = 0;
        m_rx = '0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      int kend;
      int p;
      kend = D * (2 + 2 * m_n);
      if (!m_active || m_k > kend) begin
        chk("idle ss_n", ss_n, 1);
        chk("idle sck", sck, 0);
        chk("idle mosi", mosi, 0);
        chk("idle ready", cmd_ready, 1);
        chk("idle busy", busy, 0);
        chk("idle rx_valid", rx_valid, 0);
        chk("idle rx_data", rx_data, m_rx);
      end else if (m_k == kend) begin
        chk("done ss_n", ss_n, 1);
        chk("done ready", cmd_ready, 1);
        chk("done rx_valid", rx_valid, 1);
        chk("done rx_data", rx_data, m_rx);
      end else begin
        chk("run ready", cmd_ready, 0);
        chk("run busy", busy, 1);
        chk("run rx_valid", rx_valid, 0);
        if (m_k >= D * (1 + 2 * m_n)) begin
          chk("gap ss_n", ss_n, 1);
          chk("gap sck", sck, 0);
          chk("gap mosi", mosi, 0);
        end else begin
          p = m_k / D;
          chk("frame ss_n", ss_n, 0);
          chk("frame sck", sck, p % 2);
          if (p == 0) chk("frame mosi", mosi, m_bits[0]);
          else if (p % 2 == 1) chk("frame mosi", mosi, m_bits[(p - 1) / 2]);
          else chk("frame mosi", mosi, m_bits[(p / 2 < m_n) ? p / 2 : m_n - 1]);
        end
      end
    end
  end

  // Observers for the literal checks.
  int          mon_pulses = 0;
  logic [39:0] mon_bits = '0;
  int          rv_cnt = 0;
  int          low_run = 0;
  int          hi_run = 0;
  int          last_low = 0;
  int          last_hi = 0;
  logic        ss_prev = 1'b1;

  always @(posedge sck) begin
    mon_pulses++;
    mon_bits = {mon_bits[38:0], mosi};
  end

  always @(posedge clk) if (rx_valid) rv_cnt++;

  always @(negedge clk) begin
    if (rst_n) begin
      if (!ss_n) begin
        if (ss_prev) begin
          last_hi = hi_run;
          low_run = 0;
        end
        low_run++;
      end else begin
        if (!ss_prev) last_low = low_run;
        hi_run = ss_prev ? hi_run + 1 : 1;
      end
      ss_prev = ss_n;
    end
  end

  task automatic start(input logic [7:0] c, input logic [31:0] p, input logic [2:0] l,
                       input logic [1:0] md);
    @(posedge clk);
    #1;
    cmd = c;
    payload = p;
    len = l;
    mode = md;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rv(input string name, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rx_valid && lat < 2000);
    if (lat >= 2000) chk({name, " timeout"}, 0, 1);
  endtask

  initial begin
    int lat;
    int base;
    int rdy_hi;
    int rv0;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd = '0;
    payload = '0;
    len = '0;
    mode = 2'd0;
    #12;
    chk("rst ready", cmd_ready, 1);
    chk("rst busy", busy, 0);
    chk("rst ss_n", ss_n, 1);
    chk("rst sck", sck, 0);
    chk("rst mosi", mosi, 0);
    chk("rst rx_valid", rx_valid, 0);
    chk("rst rx_data", rx_data, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1) cmd only, miso low
    base = mon_pulses;
    start(8'h15, 32'h0, 3'd0, 2'd0);
    wait_rv("t1", lat);
    chk("t1 latency", lat, 37);
    chk("t1 pulses", mon_pulses - base, 8);
    chk("t1 mosi bits", mon_bits[7:0], 8'h15);
    chk("t1 ss_n low", last_low, 34);
    chk("t1 rx_data", rx_data, 0);

    // 2) full payload, loopback
    base = mon_pulses;
    start(8'h1E, 32'hDEADBEEF, 3'd4, 2'd2);
    wait_rv("t2", lat);
    chk("t2 latency", lat, 165);
    chk("t2 pulses", mon_pulses - base, 40);
    chk("t2 mosi bits", mon_bits, 40'h1EDEADBEEF);
    chk("t2 rx_data", rx_data, 32'hDEADBEEF);

    // 3) miso high, one payload byte
    base = mon_pulses;
    start(8'hC3, 32'h12345678, 3'd1, 2'd1);
    wait_rv("t3", lat);
    chk("t3 pulses", mon_pulses - base, 16);
    chk("t3 mosi bits", mon_bits[15:0], 16'hC312);
    chk("t3 rx_data", rx_data, 32'h0000FFFF);

    // 4) len clamped to 4
    base = mon_pulses;
    start(8'hA5, 32'h01020304, 3'd7, 2'd0);
    wait_rv("t4", lat);
    chk("t4 latency", lat, 165);
    chk("t4 pulses", mon_pulses - base, 40);
    chk("t4 mosi bits", mon_bits, 40'hA501020304);

    // 5) cmd_valid held high: second frame taken in the rx_valid cycle
    @(posedge clk);
    #1;
    cmd = 8'h3C;
    payload = 32'hAA000000;
    len = 3'd1;
    mode = 2'd2;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd = 8'hFF;
    payload = 32'h55000000;
    len = 3'd0;
    rdy_hi = 0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!rx_valid && cmd_ready) rdy_hi++;
    end while (!rx_valid && lat < 2000);
    chk("t5 ready low", rdy_hi, 0);
    chk("t5 first latency", lat, 69);
    chk("t5 first rx_data", rx_data, 32'h00003CAA);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_rv("t5b", lat);
    chk("t5 second latency", lat, 37);
    chk("t5 second rx_data", rx_data, 32'h000000FF);
    chk("t5 ss_n gap", last_hi, D + 1);

    // 6) reset during bit 3 of payload byte 2
    base = mon_pulses;
    start(8'h81, 32'hCAFEF00D, 3'd4, 2'd2);
    lat = 0;
    while (mon_pulses - base < 20 && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    chk("t6 reached bit", mon_pulses - base, 20);
    rv0 = rv_cnt;
    #1 rst_n = 1'b0;
    #1;
    chk("t6 ss_n", ss_n, 1);
    chk("t6 sck", sck, 0);
    chk("t6 mosi", mosi, 0);
    chk("t6 ready", cmd_ready, 1);
    chk("t6 rx_data", rx_data, 0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6 no rx_valid", rv_cnt - rv0, 0);
    base = mon_pulses;
    start(8'h42, 32'h0, 3'd0, 2'd0);
    wait_rv("t6b", lat);
    chk("t6 after latency", lat, 37);
    chk("t6 after pulses", mon_pulses - base, 8);
    chk("t6 after mosi", mon_bits[7:0], 8'h42);
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
